// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: pipeline records,
// data-bus request/response, status codes and FSM states.
package memory_stage_pkg;

  typedef logic [2:0] stat_t;
  localparam stat_t STAT_AOK  = 3'd0;
  localparam stat_t STAT_HLT  = 3'd1;
  localparam stat_t STAT_INS  = 3'd2;
  localparam stat_t STAT_ADEL = 3'd3;
  localparam stat_t STAT_ADES = 3'd4;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef logic [1:0] msize_t;
  localparam msize_t MSIZE1 = 2'd0;
  localparam msize_t MSIZE2 = 2'd1;
  localparam msize_t MSIZE4 = 2'd2;

  typedef struct packed {
    logic [31:0] valE;
    logic [31:0] valA;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    stat_t       stat;
    logic [31:0] pc;
  } plr_m_t;

  typedef struct packed {
    logic [31:0] valE;
    logic [31:0] valM;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    stat_t       stat;
    logic [31:0] pc;
  } plr_w_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE, ADDR, DATA, HOLD
  } ms_state_t;

  function automatic logic is_mem_op(
    input logic [5:0] op
  );
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/memory_stage_req_gen.sv
// Combinational translation of an execute record into a
// data-bus request plus a word-misalignment flag.
import memory_stage_pkg::*;

module mem_req_gen #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic [31:0] vale_i,
  input  logic [31:0] vala_i,
  input  logic [5:0]  opcode_i,
  output dbus_req_t   req_o,
  output logic        misalign_o
);

  logic mem;
  logic sw;

  always_comb begin
    mem = is_mem_op(opcode_i);
    sw  = (opcode_i == OP_SW);
    misalign_o = ALIGN_CHECK && mem &&
                 (vale_i[1:0] != 2'b00);
    req_o        = '0;
    req_o.valid  = mem & ~misalign_o;
    // Without the check the low bits are simply dropped
    req_o.addr   = ALIGN_CHECK ? vale_i
                 : {vale_i[31:2], 2'b00};
    req_o.size   = MSIZE4;
    req_o.strobe = sw ? 4'hF : 4'h0;
    req_o.data   = sw ? vala_i : '0;
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: accepts plr_m, runs the LW/SW bus
// transaction and presents plr_w to writeback.
import memory_stage_pkg::*;

module memory_stage #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  plr_m_t     r_m,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic       out_valid,
  input  logic       out_ready,
  output plr_w_t     r_w
);

  ms_state_t state_q, state_d;
  plr_w_t    r_w_q;
  dbus_req_t dreq_q;
  dbus_req_t req_w;
  logic      lw_q;
  logic      misalign;
  logic      aerr;
  logic      go_bus;
  logic      accept;
  logic      data_done;
  logic      unused_funct;

  mem_req_gen #(
    .ALIGN_CHECK(ALIGN_CHECK)
  ) u_req (
    .vale_i    (r_m.valE),
    .vala_i    (r_m.valA),
    .opcode_i  (r_m.opcode),
    .req_o     (req_w),
    .misalign_o(misalign)
  );

  assign unused_funct = ^r_m.funct;

  // An earlier exception keeps its own status
  assign aerr   = misalign & (r_m.stat == STAT_AOK);
  assign go_bus = req_w.valid & (r_m.stat == STAT_AOK);

  always_comb begin
    in_ready = (state_q == IDLE) |
               ((state_q == HOLD) & out_ready);
    accept = in_valid & in_ready;
    data_done = dresp.data_ok &
                ((state_q == DATA) |
                 ((state_q == ADDR) & dresp.addr_ok));
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)
              state_d = go_bus ? ADDR : HOLD;
      ADDR: if (dresp.addr_ok)
              state_d = dresp.data_ok ? HOLD : DATA;
      DATA: if (dresp.data_ok)
              state_d = HOLD;
      HOLD: if (out_ready)
              state_d = !accept ? IDLE
                      : go_bus  ? ADDR : HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      r_w_q   <= '0;
      dreq_q  <= '0;
      lw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        r_w_q.valE <= r_m.valE;
        r_w_q.valM <= '0;
        r_w_q.pc   <= r_m.pc;
        r_w_q.dstE <= aerr ? '0 : r_m.dstE;
        r_w_q.dstM <= aerr ? '0 : r_m.dstM;
        r_w_q.stat <= !aerr ? r_m.stat
                    : (r_m.opcode == OP_LW)
                    ? STAT_ADEL : STAT_ADES;
        dreq_q       <= req_w;
        dreq_q.valid <= go_bus;
        lw_q         <= (r_m.opcode == OP_LW);
      end
      if ((state_q == ADDR) && dresp.addr_ok)
        dreq_q.valid <= 1'b0;
      if (data_done)
        r_w_q.valM <= lw_q ? dresp.data : '0;
    end
  end

  assign dreq      = dreq_q;
  assign r_w       = r_w_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized checks of memory_stage against
// a transaction-level model of the stage.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  plr_m_t     r_m = '0;
  dbus_resp_t dresp = '0;
  logic       in_ready;
  logic       out_valid;
  dbus_req_t  dreq;
  plr_w_t     r_w;

  int n_cmp = 0;
  int n_bad = 0;

  memory_stage dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .r_m      (r_m),
    .dreq     (dreq),
    .dresp    (dresp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r_w      (r_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic plr_m_t mk(
    input logic [5:0] op, input logic [31:0] ve,
    input logic [31:0] va, input logic [4:0] de,
    input logic [4:0] dm, input stat_t st,
    input logic [31:0] pc);
    plr_m_t m;
    m = '0;
    m.opcode = op; m.valE = ve; m.valA = va;
    m.dstE = de; m.dstM = dm; m.stat = st; m.pc = pc;
    return m;
  endfunction

  function automatic logic is_ls(input plr_m_t m);
    return m.opcode == 6'h23 || m.opcode == 6'h2b;
  endfunction

  function automatic logic bad_addr(input plr_m_t m);
    return m.stat == STAT_AOK && is_ls(m) &&
           (m.valE % 4) != 0;
  endfunction

  function automatic logic uses_bus(input plr_m_t m);
    return m.stat == STAT_AOK && is_ls(m) &&
           (m.valE % 4) == 0;
  endfunction

  // Expected writeback record given the bus read data
  function automatic plr_w_t model(input plr_m_t m,
                                   input logic [31:0] d);
    plr_w_t w;
    w.valE = m.valE;
    w.pc   = m.pc;
    w.dstE = bad_addr(m) ? 5'd0 : m.dstE;
    w.dstM = bad_addr(m) ? 5'd0 : m.dstM;
    w.stat = m.stat;
    if (bad_addr(m))
      w.stat = (m.opcode == 6'h23) ? 3'd3 : 3'd4;
    w.valM = (uses_bus(m) && m.opcode == 6'h23)
           ? d : 32'd0;
    return w;
  endfunction

  function automatic plr_m_t rnd();
    plr_m_t m;
    logic [5:0] ops [5];
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_ADDIU;
    ops[3] = 6'($urandom); ops[4] = OP_LW;
    m = '0;
    m.opcode = ops[$urandom_range(0, 4)];
    m.funct  = 6'($urandom);
    m.valE   = $urandom;
    if ($urandom_range(0, 3) != 0) m.valE[1:0] = 2'b00;
    m.valA = $urandom;
    m.dstE = 5'($urandom);
    m.dstM = (m.opcode == OP_SW) ? 5'd0 : 5'($urandom);
    m.stat = ($urandom_range(0, 7) == 0)
           ? 3'($urandom_range(1, 2)) : STAT_AOK;
    m.pc = $urandom;
    return m;
  endfunction

  localparam int N = 300;

  initial begin
    plr_m_t m;
    plr_m_t m2;
    plr_w_t w_hold;
    plr_m_t q[$];
    logic pending;
    logic acked;
    logic [31:0] bus_data;
    int issued;
    int done;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dreq_valid", dreq.valid, 0);
    chk("rst_r_w", r_w, '0);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // ADDIU pass-through, latency 1
    cyc();
    m = mk(OP_ADDIU, 32'h10, 0, 5, 0, STAT_AOK, 32'h1000);
    r_m = m; in_valid = 1'b1;
    #1;
    chk("addiu_in_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; #1;
    chk("addiu_out_valid", out_valid, 1);
    chk("addiu_r_w", r_w, model(m, 0));
    chk("addiu_no_dreq", dreq.valid, 0);
    cyc(); #1;
    chk("addiu_drained", out_valid, 0);

    // LW: addr_ok at cycle 2, data_ok at cycle 4
    m = mk(OP_LW, 32'h8000_0100, 0, 0, 7, STAT_AOK,
           32'h1004);
    r_m = m; in_valid = 1'b1;
    cyc(); in_valid = 1'b0; #1;
    chk("lw_dreq_valid", dreq.valid, 1);
    chk("lw_addr", dreq.addr, 32'h8000_0100);
    chk("lw_strobe", dreq.strobe, 4'h0);
    chk("lw_size", dreq.size, MSIZE4);
    chk("lw_in_ready_c1", in_ready, 0);
    cyc(); dresp.addr_ok = 1'b1; #1;
    chk("lw_addr_stable", dreq.addr, 32'h8000_0100);
    chk("lw_valid_stable", dreq.valid, 1);
    chk("lw_in_ready_c2", in_ready, 0);
    cyc(); dresp = '0; dresp.data = 32'h0BAD_0BAD; #1;
    chk("lw_data_no_req", dreq.valid, 0);
    chk("lw_in_ready_c3", in_ready, 0);
    chk("lw_out_wait", out_valid, 0);
    cyc();
    dresp.data_ok = 1'b1; dresp.data = 32'hDEAD_BEEF;
    #1;
    chk("lw_in_ready_c4", in_ready, 0);
    cyc(); dresp = '0; #1;
    chk("lw_out_valid", out_valid, 1);
    chk("lw_valM", r_w.valM, 32'hDEAD_BEEF);
    chk("lw_r_w", r_w, model(m, 32'hDEAD_BEEF));

    // SW with addr_ok and data_ok together
    cyc();
    m = mk(OP_SW, 32'h40, 32'h1234_5678, 3, 0, STAT_AOK,
           32'h1008);
    r_m = m; in_valid = 1'b1;
    #1;
    chk("sw_in_ready", in_ready, 1);
    cyc(); in_valid = 1'b0;
    dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1;
    dresp.data = 32'hCAFE_F00D;
    #1;
    chk("sw_dreq_valid", dreq.valid, 1);
    chk("sw_strobe", dreq.strobe, 4'hF);
    chk("sw_data", dreq.data, 32'h1234_5678);
    chk("sw_addr", dreq.addr, 32'h40);
    cyc(); dresp = '0; #1;
    chk("sw_hold", out_valid, 1);
    chk("sw_r_w", r_w, model(m, 0));

    // misaligned LW, then backpressure in HOLD
    cyc();
    m = mk(OP_LW, 32'h102, 0, 4, 9, STAT_AOK, 32'h100C);
    r_m = m; in_valid = 1'b1;
    #1;
    chk("adel_b2b_accept", in_ready, 1);
    cyc(); in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("adel_out_valid", out_valid, 1);
    chk("adel_stat", r_w.stat, STAT_ADEL);
    chk("adel_dstM", r_w.dstM, 0);
    chk("adel_no_dreq", dreq.valid, 0);
    w_hold = r_w;
    chk("adel_r_w", w_hold, model(m, 0));
    m2 = mk(OP_ADDIU, 32'h77, 0, 12, 0, STAT_AOK,
            32'h1010);
    for (int k = 0; k < 3; k++) begin
      cyc(); r_m = m2; in_valid = 1'b1; #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_r_w_stable", r_w, model(m, 0));
    end
    cyc(); out_ready = 1'b1; #1;
    chk("bp_release_accept", in_ready, 1);
    cyc(); in_valid = 1'b0; #1;
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_r_w", r_w, model(m2, 0));

    // reset while waiting for data_ok
    cyc();
    m = mk(OP_LW, 32'h200, 0, 0, 6, STAT_AOK, 32'h1014);
    r_m = m; in_valid = 1'b1;
    cyc(); in_valid = 1'b0; dresp.addr_ok = 1'b1; #1;
    chk("rstx_addr_phase", dreq.valid, 1);
    cyc(); dresp = '0; #1;
    chk("rstx_data_phase", in_ready, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstx_out_valid", out_valid, 0);
    chk("rstx_dreq_valid", dreq.valid, 0);
    chk("rstx_r_w", r_w, '0);
    cyc();
    resetn = 1'b1;
    dresp.data_ok = 1'b1; dresp.data = 32'h5555_AAAA;
    #1;
    chk("rstx_idle", in_ready, 1);
    cyc(); dresp = '0; #1;
    chk("rstx_late_ignored", out_valid, 0);
    chk("rstx_no_req", dreq.valid, 0);

    // randomized traffic against the queue model
    pending = 1'b0; acked = 1'b0; bus_data = '0;
    issued = 0; done = 0;
    for (int c = 0; c < 20000 && done < N; c++) begin
      cyc();
      chk("rnd_out_valid", out_valid,
          q.size() > 0 && !pending);
      chk("rnd_dreq_valid", dreq.valid,
          pending && !acked);
      if (dreq.valid && q.size() > 0) begin
        chk("rnd_addr", dreq.addr, q[$].valE);
        chk("rnd_strobe", dreq.strobe,
            (q[$].opcode == OP_SW) ? 4'hF : 4'h0);
        if (q[$].opcode == OP_SW)
          chk("rnd_wdata", dreq.data, q[$].valA);
      end
      dresp = '0;
      dresp.data = $urandom;
      if (pending && !acked) begin
        dresp.addr_ok = 1'($urandom_range(0, 1));
        dresp.data_ok = dresp.addr_ok &
                        1'($urandom_range(0, 1));
      end else if (pending) begin
        dresp.data_ok = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (issued < N) &&
                 ($urandom_range(0, 3) != 0);
      r_m = rnd();
      #1;
      chk("rnd_in_ready", in_ready,
          q.size() == 0 || (!pending && out_ready));
      if (out_valid && out_ready && q.size() > 0) begin
        m = q.pop_front();
        chk("rnd_r_w", r_w, model(m, bus_data));
        done++;
      end
      if (dresp.addr_ok) acked = 1'b1;
      if (dresp.data_ok) begin
        pending = 1'b0;
        bus_data = dresp.data;
      end
      if (in_valid && in_ready) begin
        q.push_back(r_m);
        issued++;
        if (uses_bus(r_m)) begin
          pending = 1'b1;
          acked = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    dresp = '0;
    chk("rnd_all_done", done, N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
